// File: rtl/calc_key_sequencer_pkg.sv
// Shared definitions for the calculator key sequencer: key tokens,
// FSM state encoding, default sizing and key classification helpers.
package calc_key_sequencer_pkg;

  // Default operand sizing: 4 decimal digits fit in 14 bits (9999 < 16384).
  localparam int DIGITS_DEF = 4;
  localparam int W_DEF      = 14;

  // Key tokens produced by the PS/2 decoder.
  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_ENTER     = 5'd10;
  localparam logic [4:0] KEY_PLUS      = 5'd11;
  localparam logic [4:0] KEY_MINUS     = 5'd12;
  localparam logic [4:0] KEY_MUL       = 5'd13;
  localparam logic [4:0] KEY_DIV       = 5'd14;
  localparam logic [4:0] KEY_FACT      = 5'd15;
  localparam logic [4:0] KEY_POW       = 5'd16;
  localparam logic [4:0] KEY_ROOT      = 5'd17;
  localparam logic [4:0] KEY_ESC       = 5'd18;
  localparam logic [4:0] KEY_BREAK     = 5'd30;
  localparam logic [4:0] KEY_UNKNOWN   = 5'd31;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_ENTA  = 3'd0,
    ST_ENTB  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SHOW  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code <= KEY_DIGIT_MAX);
  endfunction

  // Operators taking two operands.
  function automatic logic is_binary_op(input logic [4:0] code);
    return (code == KEY_PLUS) || (code == KEY_MINUS) || (code == KEY_MUL) ||
           (code == KEY_DIV)  || (code == KEY_POW);
  endfunction

  // Operators acting on operand A alone.
  function automatic logic is_unary_op(input logic [4:0] code);
    return (code == KEY_FACT) || (code == KEY_ROOT);
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Operation/result handshake between the key sequencer (master) and the
// arithmetic unit (slave).
import calc_key_sequencer_pkg::*;

interface calc_key_sequencer_if #(parameter int W = W_DEF);
  logic         op_valid;
  logic         op_ready;
  logic [4:0]   op_code;
  logic [W-1:0] opnd_a;
  logic [W-1:0] opnd_b;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_err;

  modport master (
    output op_valid, op_code, opnd_a, opnd_b,
    input  op_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  op_valid, op_code, opnd_a, opnd_b,
    output op_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/calc_key_sequencer_bcd_accumulator.sv
// Decimal operand accumulator: acc = acc*10 + digit, limited to DIGITS
// digits. 'start' replaces the value with a single digit, 'clr' zeroes it.
import calc_key_sequencer_pkg::*;

module bcd_accumulator #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int W      = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic         add,
  input  logic [3:0]   digit,
  output logic [W-1:0] acc
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [CW-1:0] count;
  logic [W-1:0]  acc_shifted;
  logic          room;

  // Multiply-by-10-and-add via shifts; cannot overflow thanks to the digit limit.
  always_comb begin
    acc_shifted = (acc << 3) + (acc << 1) + W'(digit);
    room        = (count < CW'(DIGITS));
  end

  // Accumulator value and held-digit count; start wins over clear and add.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc   <= {W{1'b0}};
      count <= {CW{1'b0}};
    end else if (start) begin
      acc   <= W'(digit);
      count <= CW'(1);
    end else if (clr) begin
      acc   <= {W{1'b0}};
      count <= {CW{1'b0}};
    end else if (add && room) begin
      acc   <= acc_shifted;
      count <= count + CW'(1);
    end else begin
      acc   <= acc;
      count <= count;
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: filters break codes, builds decimal operands,
// captures the operator and issues one operation at a time to the ALU.
// Optional feature macro: CALC_CHAIN_EN -- an operator pressed while a
// result is shown reuses that result as operand A.
import calc_key_sequencer_pkg::*;

module calc_key_sequencer #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int W      = W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            key_code,
  input  logic                  key_stb,
  calc_key_sequencer_if.master  bus,
  output logic [W-1:0]          disp_value,
  output logic                  err,
  output logic                  busy
);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] a;
  logic [W-1:0] a_next;
  logic [W-1:0] b;
  logic [W-1:0] b_next;
  logic [4:0]   op;
  logic [4:0]   op_next;
  logic         err_next;
  logic         brk;
  logic         brk_next;
  logic         esc_pend;
  logic         esc_pend_next;
  logic         req_valid;
  logic [W-1:0] disp_next;
  logic [W-1:0] acc;
  logic         acc_clr;
  logic         acc_start;
  logic         acc_add;
  logic         clear_all;
  logic         key_act;
  logic         key_esc;

  bcd_accumulator #(.DIGITS(DIGITS), .W(W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .start (acc_start),
    .add   (acc_add),
    .digit (key_code[3:0]),
    .acc   (acc)
  );

  // A usable keystroke: strobed, not swallowed by a pending break, not a prefix/unknown.
  always_comb begin
    key_act = key_stb && !brk && (key_code != KEY_BREAK) && (key_code != KEY_UNKNOWN);
    key_esc = key_act && (key_code == KEY_ESC);
  end

  // Next-state and datapath control for the sequencer FSM.
  always_comb begin
    state_next    = state;
    a_next        = a;
    b_next        = b;
    op_next       = op;
    err_next      = err;
    esc_pend_next = esc_pend;
    acc_clr       = 1'b0;
    acc_start     = 1'b0;
    acc_add       = 1'b0;
    clear_all     = 1'b0;

    case (state)
      ST_ENTA: begin
        if (key_esc) begin
          clear_all = 1'b1;
        end else if (key_act && is_digit(key_code)) begin
          acc_add = 1'b1;
        end else if (key_act && is_binary_op(key_code)) begin
          a_next     = acc;
          acc_clr    = 1'b1;
          op_next    = key_code;
          state_next = ST_ENTB;
        end else if (key_act && is_unary_op(key_code)) begin
          a_next     = acc;
          b_next     = {W{1'b0}};
          op_next    = key_code;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_ENTA;
        end
      end

      ST_ENTB: begin
        if (key_esc) begin
          clear_all = 1'b1;
        end else if (key_act && is_digit(key_code)) begin
          acc_add = 1'b1;
        end else if (key_act && is_binary_op(key_code)) begin
          op_next = key_code;
        end else if (key_act && (key_code == KEY_ENTER)) begin
          b_next     = acc;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_ENTB;
        end
      end

      ST_ISSUE: begin
        if (key_esc) begin
          esc_pend_next = 1'b1;
        end else begin
          esc_pend_next = esc_pend;
        end
        if (bus.op_ready) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        // A result takes priority over any keystroke in the same cycle.
        if (bus.res_valid && esc_pend) begin
          clear_all = 1'b1;
        end else if (bus.res_valid && bus.res_err) begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end else if (bus.res_valid) begin
          a_next     = bus.res_data;
          acc_clr    = 1'b1;
          state_next = ST_SHOW;
        end else if (key_esc) begin
          esc_pend_next = 1'b1;
        end else begin
          state_next = ST_WAIT;
        end
      end

      ST_SHOW: begin
        if (key_esc) begin
          clear_all = 1'b1;
        end else if (key_act && is_digit(key_code)) begin
          a_next     = {W{1'b0}};
          acc_start  = 1'b1;
          state_next = ST_ENTA;
`ifdef CALC_CHAIN_EN
        end else if (key_act && is_binary_op(key_code)) begin
          acc_clr    = 1'b1;
          op_next    = key_code;
          state_next = ST_ENTB;
        end else if (key_act && is_unary_op(key_code)) begin
          b_next     = {W{1'b0}};
          op_next    = key_code;
          state_next = ST_ISSUE;
`endif
        end else begin
          state_next = ST_SHOW;
        end
      end

      ST_ERR: begin
        if (key_esc) begin
          clear_all = 1'b1;
        end else begin
          state_next = ST_ERR;
        end
      end

      default: begin
        clear_all = 1'b1;
      end
    endcase

    // Escape (immediate or deferred) wipes the whole calculation, including break state.
    if (clear_all) begin
      state_next    = ST_ENTA;
      a_next        = {W{1'b0}};
      b_next        = {W{1'b0}};
      op_next       = 5'd0;
      err_next      = 1'b0;
      esc_pend_next = 1'b0;
      acc_clr       = 1'b1;
      brk_next      = 1'b0;
    end else if (key_stb) begin
      brk_next = brk ? 1'b0 : (key_code == KEY_BREAK);
    end else begin
      brk_next = brk;
    end
  end

  // Display source selection; ISSUE/WAIT keep showing the last value.
  always_comb begin
    case (state)
      ST_ENTA, ST_ENTB: disp_next = acc;
      ST_SHOW:          disp_next = a;
      ST_ERR:           disp_next = {W{1'b0}};
      default:          disp_next = disp_value;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_ENTA;
    end else begin
      state <= state_next;
    end
  end

  // Operand, operator, flag and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a          <= {W{1'b0}};
      b          <= {W{1'b0}};
      op         <= 5'd0;
      err        <= 1'b0;
      brk        <= 1'b0;
      esc_pend   <= 1'b0;
      req_valid  <= 1'b0;
      busy       <= 1'b0;
      disp_value <= {W{1'b0}};
    end else begin
      a          <= a_next;
      b          <= b_next;
      op         <= op_next;
      err        <= err_next;
      brk        <= brk_next;
      esc_pend   <= esc_pend_next;
      req_valid  <= (state_next == ST_ISSUE);
      busy       <= (state_next == ST_ISSUE) || (state_next == ST_WAIT);
      disp_value <= disp_next;
    end
  end

  // Operands come straight from registers that only change outside ISSUE.
  assign bus.op_valid = req_valid;
  assign bus.op_code  = op;
  assign bus.opnd_a   = a;
  assign bus.opnd_b   = b;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: expected ALU requests are
// queued when keys are pressed and compared when the handshake fires.
`timescale 1ns/1ps
module tb_calc_key_sequencer;

  localparam int W = 14;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [4:0]   key_code;
  logic         key_stb;
  logic [W-1:0] disp_value;
  logic         err;
  logic         busy;
  int           checks;
  int           errors;
  exp_t         sb[$];

  calc_key_sequencer_if #(.W(W)) bus ();

  calc_key_sequencer #(.DIGITS(4), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_stb    (key_stb),
    .bus        (bus),
    .disp_value (disp_value),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One-cycle key strobe; returns 1 ns after the edge that captured it.
  task automatic press(input logic [4:0] code);
    key_code = code;
    key_stb  = 1'b1;
    @(posedge clk); #1;
    key_stb  = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.op = op; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic chk_disp(input string name, input logic [W-1:0] exp_v);
    checks++;
    if (disp_value !== exp_v) begin
      errors++;
      $display("FAIL %s: disp_value got %0d expected %0d", name, disp_value, exp_v);
    end
  endtask

  // ALU model: waits for a request, holds ready low for 'delay' cycles while
  // checking stability, accepts, compares with the scoreboard, then returns a result.
  task automatic serve(input logic [W-1:0] result, input logic rerr, input int delay, input logic key_with_res);
    int   waited;
    exp_t e;
    logic [4+2*W:0] snap;
    waited = 0;
    while (bus.op_valid !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (bus.op_valid !== 1'b1) begin
      errors++;
      $display("FAIL serve_timeout: op_valid got %b expected 1", bus.op_valid);
      return;
    end
    snap = {bus.op_code, bus.opnd_a, bus.opnd_b};
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.op_valid !== 1'b1 || {bus.op_code, bus.opnd_a, bus.opnd_b} !== snap) begin
        errors++;
        $display("FAIL hold_stable: valid %b req %h expected valid 1 req %h", bus.op_valid,
                 {bus.op_code, bus.opnd_a, bus.opnd_b}, snap);
      end
    end
    bus.op_ready = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got op %0d a %0d b %0d expected no request",
               bus.op_code, bus.opnd_a, bus.opnd_b);
    end else begin
      e = sb.pop_front();
      if ({bus.op_code, bus.opnd_a, bus.opnd_b} !== {e.op, e.a, e.b}) begin
        errors++;
        $display("FAIL request: got op %0d a %0d b %0d expected op %0d a %0d b %0d",
                 bus.op_code, bus.opnd_a, bus.opnd_b, e.op, e.a, e.b);
      end
    end
    @(posedge clk); #1;
    bus.op_ready = 1'b0;
    checks++;
    if (bus.op_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: op_valid got %b expected 0", bus.op_valid);
    end
    @(posedge clk); #1;
    bus.res_valid = 1'b1;
    bus.res_data  = result;
    bus.res_err   = rerr;
    if (key_with_res) begin
      key_code = 5'd5;
      key_stb  = 1'b1;
    end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    bus.res_err   = 1'b0;
    key_stb       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    checks++;
    if ({bus.op_valid, err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: valid/err/busy got %b expected 000", {bus.op_valid, err, busy});
    end
    chk_disp("reset_disp", 14'd0);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_add();
    press(5'd18);
    press(5'd1); press(5'd2); press(5'd11); press(5'd3); press(5'd4);
    idle(2);
    chk_disp("entb_disp", 14'd34);
    push_exp(5'd11, 14'd12, 14'd34);
    press(5'd10);
    checks++;
    if ({bus.op_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL enter_latency: valid/busy got %b expected 11", {bus.op_valid, busy});
    end
    serve(14'd46, 1'b0, 0, 1'b0);
    idle(2);
    chk_disp("show_result", 14'd46);
    checks++;
    if ({err, busy} !== 2'b00) begin
      errors++;
      $display("FAIL show_flags: err/busy got %b expected 00", {err, busy});
    end
  endtask

  task automatic test_digit_limit();
    press(5'd18);
    for (int i = 1; i <= 5; i++) press(5'(i));
    idle(2);
    chk_disp("digit_limit", 14'd1234);
  endtask

  task automatic test_break();
    press(5'd18);
    press(5'd7); press(5'd30); press(5'd7);
    idle(2);
    chk_disp("break_filter", 14'd7);
    press(5'd31); press(5'd3);
    idle(2);
    chk_disp("after_break", 14'd73);
  endtask

  task automatic test_error();
    press(5'd18);
    press(5'd9); press(5'd13);
    for (int i = 0; i < 4; i++) press(5'd9);
    push_exp(5'd13, 14'd9, 14'd9999);
    press(5'd10);
    serve(14'd0, 1'b1, 2, 1'b0);
    idle(2);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err got %b expected 1", err);
    end
    chk_disp("err_disp", 14'd0);
    press(5'd5);
    idle(2);
    chk_disp("err_digit_ignored", 14'd0);
    press(5'd18);
    idle(2);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err got %b expected 0", err);
    end
    press(5'd3);
    idle(2);
    chk_disp("enta_after_err", 14'd3);
  endtask

  task automatic test_escape_pending();
    press(5'd18);
    press(5'd5); press(5'd11); press(5'd6);
    push_exp(5'd11, 14'd5, 14'd6);
    press(5'd10);
    press(5'd18);
    serve(14'd11, 1'b0, 5, 1'b0);
    idle(2);
    chk_disp("esc_pend_cleared", 14'd0);
    checks++;
    if ({err, busy} !== 2'b00) begin
      errors++;
      $display("FAIL esc_pend_flags: err/busy got %b expected 00", {err, busy});
    end
    press(5'd2);
    idle(2);
    chk_disp("esc_pend_enta", 14'd2);
  endtask

  task automatic test_chain();
    press(5'd18);
    press(5'd1); press(5'd2); press(5'd11); press(5'd3); press(5'd4);
    push_exp(5'd11, 14'd12, 14'd34);
    press(5'd10);
    serve(14'd46, 1'b0, 1, 1'b0);
    idle(2);
    press(5'd12); press(5'd6);
`ifdef CALC_CHAIN_EN
    push_exp(5'd12, 14'd46, 14'd6);
    press(5'd10);
    serve(14'd40, 1'b0, 0, 1'b0);
    idle(2);
    chk_disp("chain_result", 14'd40);
`else
    idle(2);
    chk_disp("nochain_new_operand", 14'd6);
    press(5'd10);
    idle(1);
    checks++;
    if (bus.op_valid !== 1'b0) begin
      errors++;
      $display("FAIL enta_enter_ignored: op_valid got %b expected 0", bus.op_valid);
    end
    press(5'd11); press(5'd4);
    push_exp(5'd11, 14'd6, 14'd4);
    press(5'd10);
    serve(14'd10, 1'b0, 0, 1'b0);
    idle(2);
    chk_disp("nochain_result", 14'd10);
`endif
  endtask

  task automatic test_unary_back_to_back();
    press(5'd18);
    press(5'd5);
    push_exp(5'd15, 14'd5, 14'd0);
    press(5'd15);
    checks++;
    if (bus.op_valid !== 1'b1) begin
      errors++;
      $display("FAIL unary_issue: op_valid got %b expected 1", bus.op_valid);
    end
    serve(14'd120, 1'b0, 0, 1'b1);
    idle(2);
    chk_disp("unary_key_dropped", 14'd120);
  endtask

  task automatic test_reset_mid();
    press(5'd18);
    press(5'd1); press(5'd11); press(5'd2); press(5'd10);
    checks++;
    if (bus.op_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: op_valid got %b expected 1", bus.op_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if ({bus.op_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: valid/busy got %b expected 00", {bus.op_valid, busy});
    end
    idle(2);
    chk_disp("reset_mid_disp", 14'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    key_code      = 5'd0;
    key_stb       = 1'b0;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_err   = 1'b0;
    test_reset();
    test_basic_add();
    test_digit_limit();
    test_break();
    test_error();
    test_escape_pending();
    test_chain();
    test_unary_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Sequences decoded keystrokes from the PS/2 receiver into calculator operations. Filters break (release) sequences, accumulates decimal digits into operands, captures the operator, and issues one operation at a time to the arithmetic unit over a valid/ready handshake. Sits between the PS/2 receiver's 5-bit key token output and the ALU/display path.

## Interface
- `DIGITS`, 4: maximum decimal digits per operand.
- `W`, 14: operand/result width; must satisfy 2^W > 10^DIGITS − 1.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `key_code`  in  5: decoded token; 0–9 digits, 10 enter, 11 plus, 12 minus, 13 multiply, 14 divide, 15 factorial, 16 power, 17 root, 18 escape, 30 release prefix, 31 unknown.
- `key_stb`  in  1: one-cycle strobe, already synchronized to `clk`; `key_code` is valid only while it is high.
- `op_valid`  out  1: operation request.
- `op_ready`  in  1: ALU accepts the request.
- `op_code`  out  5: operator token (11–17).
- `opnd_a`, `opnd_b`  out  W: operands; `opnd_b` = 0 for unary ops.
- `res_valid`  in  1: one-cycle result strobe from the ALU.
- `res_data`  in  W: result.
- `res_err`  in  1: overflow or domain error; qualified by `res_valid`.
- `disp_value`  out  W: value to display.
- `err`  out  1: error indicator.
- `busy`  out  1: high in ISSUE and WAIT.

## Operation
- Break filter: `key_stb` with code 30 sets `brk`. The next strobe, whatever its code, is discarded and clears `brk`. Code 31 is always ignored.
- States:
  - ENTA: enter operand A. Digit: `acc = acc*10 + d`; the digit is ignored once `DIGITS` digits are held. Binary op: A←acc, acc←0, store op, go to ENTB. Unary op (15, 17): A←acc, go to ISSUE. Enter: ignored.
  - ENTB: enter operand B. Digit accumulates as in ENTA. A further binary op replaces the stored op. Enter: B←acc, go to ISSUE. Unary op: ignored.
  - ISSUE: `op_valid` = 1 with stable `op_code`/`opnd_a`/`opnd_b`. Go to WAIT in the cycle where `op_ready` = 1.
  - WAIT: on `res_valid` with `res_err` = 0: A←`res_data`, acc←0, go to SHOW. With `res_err` = 1: set `err`, go to ERR.
  - SHOW: digit clears A, starts acc = d, go to ENTA. Operator: see Configuration. Enter: ignored.
  - ERR: only escape leaves it.
- Escape (18) in ENTA/ENTB/SHOW/ERR: clear acc, A, B, op, `err`, `brk`; go to ENTA.
- Escape in ISSUE/WAIT: latched as `esc_pend`. The handshake completes, the result is discarded, then the clear is applied (ENTA). Digits and operators in ISSUE/WAIT are dropped.
- `disp_value`: acc in ENTA/ENTB, A in SHOW, 0 in ERR.
- All arithmetic is unsigned W-bit. acc*10 cannot overflow because of the digit limit.

## Timing
- Reset values: state ENTA; acc, A, B, op = 0; `op_valid`, `err`, `busy`, `brk`, `esc_pend` = 0; `disp_value` = 0.
- Keystroke to state update: 1 cycle. `disp_value` is registered and reflects the new value on the following edge.
- Enter in ENTB to `op_valid` high: 1 cycle.
- `op_valid` must not drop and operands must not change until `op_ready` is sampled high.
- Simultaneous `key_stb` and `res_valid` in WAIT: the result is processed and the key is dropped.
- Reset mid-handshake drops `op_valid` on the next edge. The ALU must tolerate this.

## Configuration
- `CALC_CHAIN_EN` defined: an operator in SHOW keeps A = result. A binary op goes to ENTB; a unary op goes to ISSUE.
- `CALC_CHAIN_EN` not defined: an operator in SHOW is ignored; only a digit or escape leaves SHOW.

## Structure
- Shared package: key token constants (0–31), state encoding, `DIGITS`/`W` defaults.
- Sub-module `bcd_accumulator`: acc register, digit count, multiply-by-10-and-add, clear.

## Test plan
- Keys 1,2,+,3,4,enter; ALU returns 46 → `op_code` = 11, A = 12, B = 34; `disp_value` = 46 in SHOW.
- Keys 1,2,3,4,5 → `disp_value` = 1234; fifth digit ignored.
- Key 7, then release prefix (30), then 7 → the second 7 is discarded; `disp_value` = 7.
- A = 9, op = multiply, B = 9999; ALU returns `res_err` → `err` = 1, `disp_value` = 0; escape → ENTA, `err` = 0.
- Escape during ISSUE with `op_ready` held low for 5 cycles → `op_valid` stays high until ready; after `res_valid`, state is ENTA with acc = 0.
- Chain case: after result 46, key minus then 6, enter → with `CALC_CHAIN_EN`: A = 46, B = 6. Without it: minus is ignored and the 6 starts a new operand, `disp_value` = 6.
